fetch_stage: RTL and testbench

Instruction-fetch stage with integrated IF/ID pipeline register. It owns PC_F, issues requests to a variable-latency instruction memory with at most one outstanding request, and delivers fetched instructions to Decode. It consumes Stall_F, Stall_D and Flush_D from the hazard unit, and takes PCSrc_E and PCTarget_E from Execute. Cycles with no instruction available load a bubble into IF/ID, so the hazard unit needs no knowledge of memory latency.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/if_id_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types and constants.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load; reset and flush share the bubble value.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic            i_hold,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus4,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_hold) begin
            r_instr    <= r_instr;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end else if (i_bubble) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding imem request, redirect/drop handling and IF/ID register.
// imem handshake: a request transfers on a cycle where imem_req && imem_ready; responses come back in order.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall_F,
    input  logic            Stall_D,
    input  logic            Flush_D,
    input  logic            PCSrc_E,
    input  logic [XLEN-1:0] PCTarget_E,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instr_D,
    output logic [XLEN-1:0] PC_D,
    output logic [XLEN-1:0] PCPlus4_D,
    output logic            Valid_D,
    output fetch_state_t    o_state,
    output logic [XLEN-1:0] o_pc_f,
    output logic            o_drop
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc_f;
    logic [XLEN-1:0] r_buf;
    logic            r_drop;

    logic            w_stall;
    logic            w_rsp_ok;
    logic            w_avail;
    logic            w_transfer;
    logic            w_b2b;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_instr;

    assign w_stall    = Stall_F | Stall_D;
    assign w_pc_plus4 = r_pc_f + 32'd4;
    assign w_rsp_ok   = (r_state == WAIT) && imem_rvalid && !r_drop;
    assign w_avail    = w_rsp_ok || (r_state == HOLD);
    assign w_transfer = w_avail && !w_stall && !PCSrc_E;
    assign w_instr    = (r_state == HOLD) ? r_buf : imem_rdata;

    // A delivered response immediately launches the next sequential fetch.
    assign w_b2b      = (r_state == WAIT) && w_transfer;
    assign imem_req   = !rst && ((r_state == REQ) || w_b2b);
    assign imem_addr  = w_b2b ? w_pc_plus4 : r_pc_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REQ;
            r_pc_f  <= RESET_VAL;
            r_buf   <= NOP_INSTR;
            r_drop  <= 1'b0;
        end else if (PCSrc_E) begin
            r_pc_f <= PCTarget_E;
            case (r_state)
                REQ: begin
                    // Old-PC request accepted this cycle: its response must be thrown away.
                    if (imem_ready) begin
                        r_state <= WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                default: r_state <= REQ;
            endcase
        end else begin
            case (r_state)
                REQ: begin
                    if (imem_ready) r_state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= REQ;
                        end else if (w_stall) begin
                            r_buf   <= imem_rdata;
                            r_state <= HOLD;
                        end else begin
                            r_pc_f  <= w_pc_plus4;
                            r_state <= imem_ready ? WAIT : REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!w_stall) begin
                        r_pc_f  <= w_pc_plus4;
                        r_state <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end

    if_id_reg u_if_id (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_transfer),
        .i_flush    (Flush_D | PCSrc_E),
        .i_hold     (Stall_D),
        .i_bubble   (!w_transfer),
        .i_instr    (w_instr),
        .i_pc       (r_pc_f),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (Instr_D),
        .o_pc       (PC_D),
        .o_pc_plus4 (PCPlus4_D),
        .o_valid    (Valid_D)
    );

    assign o_state = r_state;
    assign o_pc_f  = r_pc_f;
    assign o_drop  = r_drop;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle-by-cycle bench for fetch_stage with a hand-driven instruction memory.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         Stall_F, Stall_D, Flush_D, PCSrc_E;
    logic [31:0]  PCTarget_E;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready, imem_rvalid;
    logic [31:0]  imem_rdata;
    logic [31:0]  Instr_D, PC_D, PCPlus4_D;
    logic         Valid_D;
    fetch_state_t o_state;
    logic [31:0]  o_pc_f;
    logic         o_drop;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .Stall_F     (Stall_F),
        .Stall_D     (Stall_D),
        .Flush_D     (Flush_D),
        .PCSrc_E     (PCSrc_E),
        .PCTarget_E  (PCTarget_E),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instr_D     (Instr_D),
        .PC_D        (PC_D),
        .PCPlus4_D   (PCPlus4_D),
        .Valid_D     (Valid_D),
        .o_state     (o_state),
        .o_pc_f      (o_pc_f),
        .o_drop      (o_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; Stall_F = 1'b0; Stall_D = 1'b0; Flush_D = 1'b0; PCSrc_E = 1'b0;
        PCTarget_E = 32'h0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (2) tick();

        // Reset state
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_instr", Instr_D, 32'h0000_0013);
        check("rst_pc_d", PC_D, 32'h0);
        check("rst_pc4_d", PCPlus4_D, 32'h0);
        check("rst_valid", 32'(Valid_D), 32'd0);
        check("rst_pc_f", o_pc_f, 32'h0);
        check("rst_state", 32'(o_state), 32'(REQ));

        // Single-cycle memory streaming
        rst = 1'b0; imem_ready = 1'b1; #1;
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000; #1;
        check("c1_valid", 32'(Valid_D), 32'd0);
        check("c1_req", 32'(imem_req), 32'd1);
        check("c1_addr", imem_addr, 32'h4);
        tick();
        imem_rdata = 32'hA000_0004; #1;
        check("c2_valid", 32'(Valid_D), 32'd1);
        check("c2_instr", Instr_D, 32'hA000_0000);
        check("c2_pc_d", PC_D, 32'h0);
        check("c2_pc4_d", PCPlus4_D, 32'h4);
        check("c2_addr", imem_addr, 32'h8);
        tick();
        imem_rdata = 32'hA000_0008; #1;
        check("c3_pc_d", PC_D, 32'h4);
        check("c3_instr", Instr_D, 32'hA000_0004);
        check("c3_addr", imem_addr, 32'hC);
        tick();

        // Stall with a response arriving during the stall
        check("c4_pc_d", PC_D, 32'h8);
        Stall_F = 1'b1; Stall_D = 1'b1; imem_rdata = 32'hA000_000C; #1;
        check("c4_req", 32'(imem_req), 32'd0);
        tick();
        imem_rvalid = 1'b0; #1;
        check("c5_state", 32'(o_state), 32'(HOLD));
        check("c5_pc_d", PC_D, 32'h8);
        check("c5_req", 32'(imem_req), 32'd0);
        tick();
        check("c6_pc_d", PC_D, 32'h8);
        check("c6_req", 32'(imem_req), 32'd0);
        tick();
        Stall_F = 1'b0; Stall_D = 1'b0; #1;
        check("c7_pc_d", PC_D, 32'h8);
        check("c7_req", 32'(imem_req), 32'd0);
        tick();
        check("c8_pc_d", PC_D, 32'hC);
        check("c8_instr", Instr_D, 32'hA000_000C);
        check("c8_pc4_d", PCPlus4_D, 32'h10);
        check("c8_valid", 32'(Valid_D), 32'd1);
        check("c8_state", 32'(o_state), 32'(REQ));
        check("c8_req", 32'(imem_req), 32'd1);
        check("c8_addr", imem_addr, 32'h10);
        tick();

        // Redirect while a request is outstanding (slow memory)
        check("c9_valid", 32'(Valid_D), 32'd0);
        PCSrc_E = 1'b1; PCTarget_E = 32'h100; #1;
        check("c9_req", 32'(imem_req), 32'd0);
        tick();
        PCSrc_E = 1'b0; #1;
        check("c10_drop", 32'(o_drop), 32'd1);
        check("c10_pc_f", o_pc_f, 32'h100);
        check("c10_state", 32'(o_state), 32'(WAIT));
        check("c10_req", 32'(imem_req), 32'd0);
        check("c10_valid", 32'(Valid_D), 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hA000_0010; #1;
        check("c11_stale_req", 32'(imem_req), 32'd0);
        tick();
        imem_rvalid = 1'b0; #1;
        check("c12_drop", 32'(o_drop), 32'd0);
        check("c12_state", 32'(o_state), 32'(REQ));
        check("c12_req", 32'(imem_req), 32'd1);
        check("c12_addr", imem_addr, 32'h100);
        check("c12_valid", 32'(Valid_D), 32'd0);
        tick();
        check("c13_req", 32'(imem_req), 32'd0);
        check("c13_valid", 32'(Valid_D), 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hA000_0100; imem_ready = 1'b0; #1;
        check("c14_req", 32'(imem_req), 32'd1);
        check("c14_addr", imem_addr, 32'h104);
        tick();
        imem_rvalid = 1'b0; imem_ready = 1'b1; #1;
        check("c15_instr", Instr_D, 32'hA000_0100);
        check("c15_pc_d", PC_D, 32'h100);
        check("c15_pc4_d", PCPlus4_D, 32'h104);
        check("c15_valid", 32'(Valid_D), 32'd1);
        check("c15_state", 32'(o_state), 32'(REQ));
        check("c15_addr", imem_addr, 32'h104);
        tick();

        // Redirect in the same cycle as a response
        imem_rvalid = 1'b1; imem_rdata = 32'hA000_0104; PCSrc_E = 1'b1; PCTarget_E = 32'h100; #1;
        check("c16_req", 32'(imem_req), 32'd0);
        check("c16_valid", 32'(Valid_D), 32'd0);
        tick();

        // Memory not ready for four cycles
        PCSrc_E = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b0; #1;
        check("c17_state", 32'(o_state), 32'(REQ));
        check("c17_pc_f", o_pc_f, 32'h100);
        for (int i = 0; i < 4; i++) begin
            check("nrdy_req", 32'(imem_req), 32'd1);
            check("nrdy_addr", imem_addr, 32'h100);
            check("nrdy_valid", 32'(Valid_D), 32'd0);
            tick();
        end
        imem_ready = 1'b1; #1;
        check("c21_req", 32'(imem_req), 32'd1);
        tick();

        // Reset while a request is outstanding
        imem_ready = 1'b0; #1;
        check("c22_state", 32'(o_state), 32'(WAIT));
        rst = 1'b1; #1;
        check("c22_rst_req", 32'(imem_req), 32'd0);
        tick();
        check("c23_pc_f", o_pc_f, 32'h0);
        check("c23_valid", 32'(Valid_D), 32'd0);
        check("c23_instr", Instr_D, 32'h0000_0013);
        check("c23_pc_d", PC_D, 32'h0);
        check("c23_state", 32'(o_state), 32'(REQ));
        check("c23_drop", 32'(o_drop), 32'd0);
        check("c23_req", 32'(imem_req), 32'd0);
        rst = 1'b0; imem_ready = 1'b1; #1;
        check("c23_req_rel", 32'(imem_req), 32'd1);
        check("c23_addr", imem_addr, 32'h0);
        tick();

        // Flush and Stall_D together: flush wins
        imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000; imem_ready = 1'b0; #1;
        check("c24_req", 32'(imem_req), 32'd1);
        check("c24_addr", imem_addr, 32'h4);
        tick();
        imem_rvalid = 1'b0; #1;
        check("c25_valid", 32'(Valid_D), 32'd1);
        check("c25_pc_d", PC_D, 32'h0);
        Flush_D = 1'b1; Stall_D = 1'b1;
        tick();
        Flush_D = 1'b0; Stall_D = 1'b0;
        check("c26_valid", 32'(Valid_D), 32'd0);
        check("c26_instr", Instr_D, 32'h0000_0013);
        check("c26_pc_d", PC_D, 32'h0);
        check("c26_pc4_d", PCPlus4_D, 32'h0);
        check("c26_pc_f", o_pc_f, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
